// File: rtl/ht_client_port.sv
// Hash-table client port: registers host commands toward the table, tracks them in issue
// order and pairs each returned result with its command (mismatch / unsolicited / timeout).
package hash_table;
    localparam int unsigned KEY_W = 16;
    localparam int unsigned VAL_W = 16;
    localparam int unsigned BKT_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        INSERT = 2'd1,
        DELETE = 2'd2
    } ht_opcode_t;

    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        INSERT_SUCCESS_SAME_KEY          = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_SUCCESS                   = 3'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
        ht_opcode_t       opcode;
    } ht_command_t;

    typedef struct packed {
        ht_command_t      cmd;
        ht_rescode_t      rescode;
        logic [BKT_W-1:0] bucket;
        logic [VAL_W-1:0] found_value;
    } ht_result_t;
endpackage

module ht_client_port
    import hash_table::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  ht_command_t                       host_cmd_i,
    input  logic                              host_valid_i,
    output logic                              host_ready_o,
    output ht_command_t                       ht_cmd_o,
    output logic                              ht_cmd_valid_o,
    input  logic                              ht_cmd_ready_i,
    input  ht_result_t                        ht_res_i,
    input  logic                              ht_res_valid_i,
    output logic                              ht_res_ready_o,
    output ht_result_t                        resp_o,
    output logic                              resp_timeout_o,
    output logic                              resp_mismatch_o,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic [CNT_WIDTH-1:0]              cnt_timeout_o,
    output logic [CNT_WIDTH-1:0]              cnt_mismatch_o,
    output logic [CNT_WIDTH-1:0]              cnt_unsolicited_o
);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    ht_command_t          trk_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    ht_command_t          cmd_q, cmd_d;
    logic                 cmd_valid_q, cmd_valid_d;
    ht_result_t           resp_q, resp_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_to_q, resp_to_d, resp_mm_q, resp_mm_d;
    logic [CNT_WIDTH-1:0] cnt_to_q, cnt_to_d, cnt_mm_q, cnt_mm_d, cnt_un_q, cnt_un_d;

    logic        push, res_acc, res_pop, unsol, to_fire, pop, empty, mism;
    ht_command_t head;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic ht_rescode_t timeout_code(input ht_opcode_t op);
        case (op)
            INSERT:  return INSERT_NOT_SUCCESS_TABLE_IS_FULL;
            DELETE:  return DELETE_NOT_SUCCESS_NO_ENTRY;
            default: return SEARCH_NOT_SUCCESS_NO_ENTRY;
        endcase
    endfunction

    // Handshakes; the full check uses the registered occupancy only
    assign host_ready_o   = (!cmd_valid_q || ht_cmd_ready_i) && (occ_q < OCC_W'(MAX_OUTSTANDING));
    assign ht_res_ready_o = !resp_valid_q || resp_ready_i;
    assign push           = host_valid_i && host_ready_o;
    assign res_acc        = ht_res_valid_i && ht_res_ready_o;
    assign empty          = (occ_q == '0);
    assign res_pop        = res_acc && !empty;
    assign unsol          = res_acc && empty;
    assign head           = trk_q[rd_ptr_q];
    assign mism           = (ht_res_i.cmd.key != head.key) || (ht_res_i.cmd.opcode != head.opcode);
    assign to_fire        = (TIMEOUT_CYCLES != 0) && !empty && (tmr_q == TMR_W'(TIMEOUT_CYCLES))
                            && ht_res_ready_o && !res_acc;
    assign pop            = res_pop || to_fire;

    always_comb begin
        cmd_d        = cmd_q;
        cmd_valid_d  = cmd_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tmr_d        = tmr_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        resp_to_d    = resp_to_q;
        resp_mm_d    = resp_mm_q;
        cnt_to_d     = cnt_to_q;
        cnt_mm_d     = cnt_mm_q;
        cnt_un_d     = cnt_un_q;

        if (push) begin
            cmd_d       = host_cmd_i;
            cmd_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        end else if (ht_cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        // Timer saturates at the limit so a blocked timeout stays pending
        if (empty || pop) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_W'(TIMEOUT_CYCLES)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        if (res_pop) begin
            resp_d       = ht_res_i;
            resp_valid_d = 1'b1;
            resp_to_d    = 1'b0;
            resp_mm_d    = mism;
            if (mism) cnt_mm_d = sat_inc(cnt_mm_q);
        end else if (to_fire) begin
            resp_d         = '0;
            resp_d.cmd     = head;
            resp_d.rescode = timeout_code(head.opcode);
            resp_valid_d   = 1'b1;
            resp_to_d      = 1'b1;
            resp_mm_d      = 1'b0;
            cnt_to_d       = sat_inc(cnt_to_q);
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end

        if (unsol) cnt_un_d = sat_inc(cnt_un_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) trk_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            tmr_q        <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_to_q    <= 1'b0;
            resp_mm_q    <= 1'b0;
            cnt_to_q     <= '0;
            cnt_mm_q     <= '0;
            cnt_un_q     <= '0;
        end else begin
            if (push) trk_q[wr_ptr_q] <= host_cmd_i;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            tmr_q        <= tmr_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            resp_to_q    <= resp_to_d;
            resp_mm_q    <= resp_mm_d;
            cnt_to_q     <= cnt_to_d;
            cnt_mm_q     <= cnt_mm_d;
            cnt_un_q     <= cnt_un_d;
        end
    end

    assign ht_cmd_o          = cmd_q;
    assign ht_cmd_valid_o    = cmd_valid_q;
    assign resp_o            = resp_q;
    assign resp_valid_o      = resp_valid_q;
    assign resp_timeout_o    = resp_to_q;
    assign resp_mismatch_o   = resp_mm_q;
    assign outstanding_o     = occ_q;
    assign cnt_timeout_o     = cnt_to_q;
    assign cnt_mismatch_o    = cnt_mm_q;
    assign cnt_unsolicited_o = cnt_un_q;
endmodule
